// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register specifiers and pipeline control FSM states.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination is read by the instruction in IF/ID.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_memread,
    input  regbits_t idex_rt,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     hazard
);

    // $zero is hardwired, so a load targeting it never creates a dependency
    assign hazard = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: prioritised stall/flush control, halt drain FSM and
// saturating stall-cycle counter.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   exmem_dmemreq,
    input  regbits_t               id_rs,
    input  regbits_t               id_rt,
    input  logic                   idex_memread,
    input  regbits_t               idex_rt,
    input  logic                   ex_redirect,
    input  logic                   mem_halt,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    ctrl_state_t            state_q, state_d;
    logic                   halt_q, halt_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hazard;

    load_use_detect u_load_use_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .hazard       (hazard)
    );

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (state_q == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (exmem_dmemreq && !dhit) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if ((state_q == RUN && mem_halt) || state_q == DRAIN) begin
            // Let the halting instruction retire while bubbling everything behind it
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = (state_q == RUN) ? DRAIN : HALTED;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        halt_d = halt_q || (state_d == HALTED);
        cnt_d  = cnt_q;
        if (!pc_en && state_q != HALTED && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halt         = halt_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl, plus reset, halt and saturation sequences.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    logic     ihit, dhit, exmem_dmemreq, idex_memread, ex_redirect, mem_halt;
    regbits_t id_rs, id_rt, idex_rt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halt;
    logic [31:0] stall_cycles;

    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halt;
    logic [3:0]  s_stall_cycles;

    logic [8:0]  outs;
    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, halt};

    // {pc,ifid,idex,exmem,memwb en}_{ifid,idex,exmem flush}_halt
    localparam logic [8:0] O_IDLE  = 9'b11111_000_0;
    localparam logic [8:0] O_LU    = 9'b00111_010_0;
    localparam logic [8:0] O_FRZ   = 9'b00000_000_0;
    localparam logic [8:0] O_REDIR = 9'b11111_110_0;
    localparam logic [8:0] O_MISS  = 9'b01111_100_0;
    localparam logic [8:0] O_DRAIN = 9'b01111_111_0;
    localparam logic [8:0] O_HALT  = 9'b00000_000_1;

    pipeline_ctrl #(.STALL_CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dmemreq(exmem_dmemreq),
        .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_redirect(ex_redirect), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt(halt), .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.STALL_CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dmemreq(exmem_dmemreq),
        .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_redirect(ex_redirect), .mem_halt(mem_halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .halt(s_halt), .stall_cycles(s_stall_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       ihit, dhit, dmemreq, memread, redirect, mhalt;
        logic [4:0] rs, rt, ex_rt;
        logic [8:0] exp;
        int         cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string name, logic ih, logic dh, logic dm, logic mr,
                                logic rd, logic mh, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] ert, logic [8:0] exp, int cnt);
        vec_t v;
        v.name = name; v.ihit = ih; v.dhit = dh; v.dmemreq = dm; v.memread = mr;
        v.redirect = rd; v.mhalt = mh; v.rs = rs; v.rt = rt; v.ex_rt = ert;
        v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; exmem_dmemreq = v.dmemreq; idex_memread = v.memread;
        ex_redirect = v.redirect; mem_halt = v.mhalt;
        id_rs = v.rs; id_rt = v.rt; idex_rt = v.ex_rt;
    endtask

    task automatic drive_idle();
        drive(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive_idle();
        #2 nRST = 1'b0;
        #1;
        check("rst_halt", {31'b0, halt}, 0);
        check("rst_cnt", stall_cycles, 0);
        check("rst_outs", {23'b0, outs}, {23'b0, O_IDLE});
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        drive_idle();
        // name ihit dhit dmemreq memread redirect mhalt rs rt ex_rt exp cnt_before_edge
        vecs.push_back(mk("idle",          1, 0, 0, 0, 0, 0,  0, 0, 0, O_IDLE,  0));
        vecs.push_back(mk("lu_rs",         1, 0, 0, 1, 0, 0,  8, 0, 8, O_LU,    0));
        vecs.push_back(mk("after_lu",      1, 0, 0, 0, 0, 0,  0, 0, 0, O_IDLE,  1));
        vecs.push_back(mk("lu_r0",         1, 0, 0, 1, 0, 0,  0, 0, 0, O_IDLE,  1));
        vecs.push_back(mk("lu_rt",         1, 0, 0, 1, 0, 0,  3, 5, 5, O_LU,    1));
        vecs.push_back(mk("frz1",          1, 0, 1, 0, 0, 0,  0, 0, 0, O_FRZ,   2));
        vecs.push_back(mk("frz2_redir",    1, 0, 1, 0, 1, 0,  0, 0, 0, O_FRZ,   3));
        vecs.push_back(mk("frz3",          1, 0, 1, 0, 0, 0,  0, 0, 0, O_FRZ,   4));
        vecs.push_back(mk("dhit",          1, 1, 1, 0, 0, 0,  0, 0, 0, O_IDLE,  5));
        vecs.push_back(mk("redir_lu",      1, 0, 0, 1, 1, 0,  8, 0, 8, O_REDIR, 5));
        vecs.push_back(mk("redir_miss",    0, 0, 0, 0, 1, 0,  0, 0, 0, O_REDIR, 5));
        vecs.push_back(mk("lu_miss",       0, 0, 0, 1, 0, 0,  9, 0, 9, O_LU,    5));
        vecs.push_back(mk("miss",          0, 0, 0, 0, 0, 0,  0, 0, 0, O_MISS,  6));
        vecs.push_back(mk("lu_nomatch",    1, 0, 0, 1, 0, 0,  4, 6, 7, O_IDLE,  7));
        vecs.push_back(mk("halt_frz",      1, 0, 1, 0, 0, 1,  0, 0, 0, O_FRZ,   7));
        vecs.push_back(mk("halt_go",       1, 1, 1, 0, 0, 1,  0, 0, 0, O_DRAIN, 8));
        vecs.push_back(mk("drain",         1, 0, 0, 0, 1, 0,  8, 0, 8, O_DRAIN, 9));
        vecs.push_back(mk("halted",        0, 0, 1, 1, 1, 1,  8, 0, 8, O_HALT,  10));

        #12;
        check("init_halt", {31'b0, halt}, 0);
        check("init_cnt", stall_cycles, 0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            check({vecs[i].name, "_outs"}, {23'b0, outs}, {23'b0, vecs[i].exp});
            check({vecs[i].name, "_cnt"}, stall_cycles, vecs[i].cnt);
        end

        // HALTED ignores every input and the counter stays put
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            {ihit, dhit, exmem_dmemreq, idex_memread, ex_redirect, mem_halt} = 6'($urandom);
            id_rs = 5'($urandom); id_rt = 5'($urandom); idex_rt = 5'($urandom);
            #1;
            check("halted_outs", {23'b0, outs}, {23'b0, O_HALT});
            check("halted_cnt", stall_cycles, 10);
        end
        do_reset();

        // Reset mid-freeze
        @(negedge CLK);
        drive(mk("f", 1, 0, 1, 0, 0, 0, 0, 0, 0, O_FRZ, 0));
        @(negedge CLK);
        #1 check("mf_cnt", stall_cycles, 1);
        #1 nRST = 1'b0;
        #1 check("mf_rst_cnt", stall_cycles, 0);
        @(negedge CLK);
        drive_idle();
        nRST = 1'b1;

        // Reset mid-drain must land in RUN, not HALTED
        @(negedge CLK);
        drive(mk("h", 1, 0, 0, 0, 0, 1, 0, 0, 0, O_DRAIN, 0));
        @(negedge CLK);
        drive_idle();
        #1 check("md_drain", {23'b0, outs}, {23'b0, O_DRAIN});
        #1 nRST = 1'b0;
        #1 check("md_rst_outs", {23'b0, outs}, {23'b0, O_IDLE});
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1 check("md_run_outs", {23'b0, outs}, {23'b0, O_IDLE});
        check("md_run_halt", {31'b0, halt}, 0);

        // Saturation on the 4-bit instance
        do_reset();
        @(negedge CLK);
        drive(mk("m", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MISS, 0));
        for (int i = 0; i <= 20; i++) begin
            #1 check("sat_cnt", {28'b0, s_stall_cycles}, (i < 15) ? i : 15);
            @(negedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing unit for the five-stage pipelined CPU. It drives enable and flush for the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It resolves data-memory waits, instruction-fetch misses, load-use hazards, taken branches/jumps and halt drain in one fixed priority order. It also counts stall cycles for performance measurement.

## Interface
- STALL_CNT_W, 32, width of the saturating stall-cycle counter
- CLK  in  1  core clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- exmem_dmemreq  in  1  instruction in EX/MEM performs a load or store
- id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID
- idex_memread  in  1  instruction in ID/EX is a load
- idex_rt  in  5  load destination register in ID/EX
- ex_redirect  in  1  taken branch or jump resolved in EX; PC mux selects target
- mem_halt  in  1  HALT instruction is in EX/MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage/PC load enable
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all-zero) on next edge
- halt  out  1  core halted; registered, sticky
- stall_cycles  out  STALL_CNT_W  cycles with pc_en=0, saturating

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Latch contract: flush wins over en. A latch with en=0 and flush=0 holds its value.
- The following rules are evaluated in priority order in RUN and DRAIN. The first matching rule sets the outputs. Outputs a rule does not name take their defaults: all en=1, all flush=0.
  1. Data freeze, exmem_dmemreq & !dhit: all five en=0 and all flush=0. No state change.
  2. Halt, mem_halt in RUN, or any cycle in DRAIN:
     - pc_en=0.
     - ifid_flush=1, idex_flush=1, exmem_flush=1.
     - memwb_en=1.
     - RUN goes to DRAIN. DRAIN goes to HALTED.
  3. Redirect, ex_redirect: ifid_flush=1, idex_flush=1, pc_en=1.
  4. Load-use:
     - Condition: idex_memread & idex_rt!=0 & (idex_rt==id_rs | idex_rt==id_rt).
     - Action: pc_en=0, ifid_en=0, idex_flush=1.
  5. Fetch miss, !ihit: pc_en=0, ifid_flush=1. Downstream stages advance.
- HALTED: all en=0, all flush=0, halt=1. Stays HALTED until nRST is asserted. All inputs are ignored.
- stall_cycles:
  - Increments by 1 on each edge where pc_en=0 and the state is not HALTED.
  - Holds at 2^STALL_CNT_W−1.
  - Resets to 0.

## Timing
- Enables and flushes are Mealy outputs, combinational from inputs and state in the same cycle. There is no registered latency.
- halt rises on the edge leaving DRAIN. That is 2 edges after mem_halt is first seen unfrozen.
- A data freeze during the mem_halt cycle delays the RUN→DRAIN transition until dhit.
- Reset values: state=RUN, halt=0, stall_cycles=0. Combinational outputs follow the RUN rules immediately after reset.
- nRST asserted mid-freeze or mid-DRAIN returns to RUN asynchronously. The counter clears.
- Simultaneous redirect and load-use: the redirect wins. The ID instruction is wrong-path and is flushed, and the PC loads the target.
- Simultaneous redirect and !ihit: the redirect wins, with pc_en=1. The fetched word is discarded by ifid_flush.
- Load-use with !ihit: the load-use rule applies. IF/ID holds because ifid_en=0 with no flush.
- Register 0 never triggers load-use.

## Structure
- Add the state enum typedef ctrl_state_t (RUN, DRAIN, HALTED) to cpu_types_pkg.
- Reuse the package's 5-bit regbits_t for id_rs, id_rt and idex_rt.
- One combinational sub-module, load_use_detect. Inputs: idex_memread, idex_rt, id_rs, id_rt. Output: hazard.
- The FSM, priority mux and counter stay in pipeline_ctrl.

## Test plan
- Reset then idle: ihit=1, dhit=0, no requests → all en=1, all flush=0, halt=0, stall_cycles=0.
- Load-use:
  - Stimulus: idex_memread=1, idex_rt=8, id_rs=8, ihit=1 for one cycle.
  - Response: pc_en=0, ifid_en=0, idex_flush=1, stall_cycles=1.
  - Repeat with idex_rt=0: no stall.
- Data freeze:
  - Stimulus: exmem_dmemreq=1, dhit=0 for 3 cycles, then dhit=1.
  - Response: all en=0 for 3 cycles, then all en=1. stall_cycles=3.
  - Assert ex_redirect=1 during the freeze: still no flush.
- Redirect versus load-use:
  - Stimulus: ex_redirect=1 together with a load-use match.
  - Response: pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=1.
- Halt drain:
  - Stimulus: mem_halt=1 for one cycle.
  - Response, that cycle and the next: exmem_flush=1, memwb_en=1.
  - Response, following cycle: halt=1 and all en=0, sticky for 10 further cycles regardless of inputs.
  - Assert nRST: halt=0.
- Counter saturation:
  - Setup: STALL_CNT_W=4, !ihit held for 20 cycles.
  - Response: stall_cycles reaches 15 and holds.
